// File: rtl/status_array_ctrl.sv
// Purpose : per-row, per-block status storage with a self-initialising sweep and an on-demand flush.
// Latency : one cycle from an accepted request to o_valid/o_tag/o_data (read-before-write).
// Backpressure: o_ready is low during a sweep and requests are dropped then; i_halt freezes everything.
module status_array_ctrl #(
  parameter int TAG_WIDTH    = 1,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_BLOCKS   = 4,
  parameter int STATUS_WIDTH = 2,
  parameter logic [STATUS_WIDTH-1:0] INIT_VALUE = '0,
  localparam int ROW_WIDTH   = NUM_BLOCKS * STATUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_flush,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ROW_WIDTH-1:0]  i_data,
  input  logic                  i_wen,
  input  logic [NUM_BLOCKS-1:0] i_wmask,
  input  logic                  i_valid,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [ROW_WIDTH-1:0]  o_data,
  output logic                  o_valid,
  output logic                  o_ready,
  output logic                  o_sweep_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [ROW_WIDTH-1:0] INIT_ROW = {NUM_BLOCKS{INIT_VALUE}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [ROW_WIDTH-1:0]  data_q, data_d;
  logic                  done_q, done_d;

  // Storage has no reset: contents are meaningless until the first sweep completes.
  logic [ROW_WIDTH-1:0]  mem_q [DEPTH];

  logic                  accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ROW_WIDTH-1:0]  wr_row;
  logic [ROW_WIDTH-1:0]  rd_row;
  logic [ROW_WIDTH-1:0]  merged_row;

  assign rd_row = mem_q[i_addr];
  assign accept = (state_q == ST_RUN) && i_valid && !i_halt;

  // Merge masked write data into the current row contents, block by block.
  always_comb begin
    merged_row = rd_row;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      if (i_wmask[b]) begin
        merged_row[b*STATUS_WIDTH +: STATUS_WIDTH] = i_data[b*STATUS_WIDTH +: STATUS_WIDTH];
      end
    end
  end

  // Next-state, response and array-write selection; a halted cycle holds every register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    done_d  = done_q;
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_row  = INIT_ROW;

    if (!i_halt) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
        ST_SWEEP: begin
          wr_en   = 1'b1;
          wr_addr = cnt_q;
          wr_row  = INIT_ROW;
          if (i_flush) begin
            // Restart wins even on the terminal row so a flush always yields a full sweep.
            cnt_d = '0;
          end else if (cnt_q == '1) begin
            cnt_d   = '0;
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
        default: begin
          if (accept) begin
            // Response carries the row as it was before this request's own write.
            valid_d = 1'b1;
            tag_d   = i_tag;
            data_d  = rd_row;
            if (i_wen) begin
              wr_en   = 1'b1;
              wr_addr = i_addr;
              wr_row  = merged_row;
            end
          end
          if (i_flush) begin
            state_d = ST_SWEEP;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // Control and response registers; reset returns to the start of a sweep and drops any response.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Single write port shared by the sweep and masked request writes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_row;
    end
  end

  assign o_valid      = valid_q;
  assign o_tag        = tag_q;
  assign o_data       = data_q;
  assign o_sweep_done = done_q;
  assign o_ready      = (state_q == ST_RUN);

endmodule

// File: tb/tb_status_array_ctrl.sv
// Bench for status_array_ctrl: two instances (INIT_VALUE 0 and 3) share one stimulus stream.
// Expected responses are queued at issue time and popped by a separate output monitor.
// Control outputs (ready / sweep_done / valid) are checked every cycle against a sweep model.
module tb_status_array_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = 4;
  localparam int SW    = 2;
  localparam int RW    = 8;
  localparam int TW    = 1;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          i_halt, i_flush, i_wen, i_valid;
  logic [TW-1:0] i_tag;
  logic [AW-1:0] i_addr;
  logic [RW-1:0] i_data;
  logic [NB-1:0] i_wmask;

  logic [TW-1:0] o_tag0, o_tag1;
  logic [RW-1:0] o_data0, o_data1;
  logic          o_valid0, o_valid1, o_ready0, o_ready1, o_done0, o_done1;

  always #5 clk = ~clk;

  status_array_ctrl #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .NUM_BLOCKS(NB), .STATUS_WIDTH(SW),
                      .INIT_VALUE(2'b00)) dut0 (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt), .i_flush(i_flush), .i_tag(i_tag),
    .i_addr(i_addr), .i_data(i_data), .i_wen(i_wen), .i_wmask(i_wmask), .i_valid(i_valid),
    .o_tag(o_tag0), .o_data(o_data0), .o_valid(o_valid0), .o_ready(o_ready0),
    .o_sweep_done(o_done0));

  status_array_ctrl #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .NUM_BLOCKS(NB), .STATUS_WIDTH(SW),
                      .INIT_VALUE(2'b11)) dut1 (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt), .i_flush(i_flush), .i_tag(i_tag),
    .i_addr(i_addr), .i_data(i_data), .i_wen(i_wen), .i_wmask(i_wmask), .i_valid(i_valid),
    .o_tag(o_tag1), .o_data(o_data1), .o_valid(o_valid1), .o_ready(o_ready1),
    .o_sweep_done(o_done1));

  typedef struct {
    logic [TW-1:0] tag;
    logic [RW-1:0] d0;
    logic [RW-1:0] d1;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: row contents per instance plus "cycles of sweep still owed".
  logic [RW-1:0] m0 [DEPTH];
  logic [RW-1:0] m1 [DEPTH];
  bit            m_ready;
  int            sweep_left;
  bit            exp_done;
  bit            exp_valid;
  logic          edge_halt = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] merge(input logic [RW-1:0] old, input logic [RW-1:0] d,
                                          input logic [NB-1:0] mk);
    logic [RW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (mk[b]) r[b*SW +: SW] = d[b*SW +: SW];
    return r;
  endfunction

  // Remember whether the last edge was halted: a halted edge means outputs are a held copy.
  always @(posedge clk) edge_halt <= i_halt;

  // Output monitor: a fresh response pops the queue, a held one must equal the last response.
  always @(negedge clk) begin
    if (arst_n === 1'b1 && o_valid0 === 1'b1) begin
      if (!edge_halt) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_resp: got data %0h with no response expected at %0t",
                   o_data0, $time);
        end else begin
          last_exp = exp_q.pop_front();
          chk("resp_tag0", 32'(o_tag0), 32'(last_exp.tag));
          chk("resp_data0", 32'(o_data0), 32'(last_exp.d0));
          chk("resp_tag1", 32'(o_tag1), 32'(last_exp.tag));
          chk("resp_data1", 32'(o_data1), 32'(last_exp.d1));
        end
      end else begin
        chk("hold_tag", 32'(o_tag0), 32'(last_exp.tag));
        chk("hold_data0", 32'(o_data0), 32'(last_exp.d0));
        chk("hold_data1", 32'(o_data1), 32'(last_exp.d1));
      end
    end
  end

  // One clock of stimulus; updates the model at the edge and checks the control outputs.
  task automatic cyc(input bit v, input bit we, input logic [AW-1:0] a, input logic [RW-1:0] d,
                     input logic [NB-1:0] mk, input logic [TW-1:0] t, input bit fl, input bit h);
    exp_t e;
    i_valid = v; i_wen = we; i_addr = a; i_data = d; i_wmask = mk; i_tag = t;
    i_flush = fl; i_halt = h;
    @(posedge clk);
    if (!h) begin
      exp_done  = 1'b0;
      exp_valid = 1'b0;
      if (!m_ready) begin
        if (fl) sweep_left = DEPTH;
        else begin
          sweep_left--;
          if (sweep_left == 0) begin
            m_ready  = 1'b1;
            exp_done = 1'b1;
            for (int r = 0; r < DEPTH; r++) begin
              m0[r] = 8'h00;
              m1[r] = 8'hFF;
            end
          end
        end
      end else begin
        if (v) begin
          exp_valid = 1'b1;
          e.tag = t; e.d0 = m0[a]; e.d1 = m1[a];
          exp_q.push_back(e);
          if (we) begin
            m0[a] = merge(m0[a], d, mk);
            m1[a] = merge(m1[a], d, mk);
          end
        end
        if (fl) begin
          m_ready    = 1'b0;
          sweep_left = DEPTH;
        end
      end
    end
    #1;
    chk("o_ready", {30'd0, o_ready1, o_ready0}, {30'd0, m_ready, m_ready});
    chk("o_sweep_done", {30'd0, o_done1, o_done0}, {30'd0, exp_done, exp_done});
    chk("o_valid", {30'd0, o_valid1, o_valid0}, {30'd0, exp_valid, exp_valid});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, '0, 0, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
    cyc(1, 0, a, '0, '0, t, 0, 0);
  endtask

  task automatic read_all();
    for (int r = 0; r < DEPTH; r++) rd(AW'(r), TW'(r));
  endtask

  // Asynchronous reset pulse: outputs must clear at once and any pending response is lost.
  task automatic do_reset();
    i_valid = 0; i_halt = 0; i_flush = 0; i_wen = 0;
    arst_n = 1'b0;
    #1;
    chk("rst_valid", {30'd0, o_valid1, o_valid0}, 32'd0);
    chk("rst_ready", {30'd0, o_ready1, o_ready0}, 32'd0);
    chk("rst_done", {30'd0, o_done1, o_done0}, 32'd0);
    chk("rst_data", {16'd0, o_data1, o_data0}, 32'd0);
    chk("rst_tag", {30'd0, o_tag1, o_tag0}, 32'd0);
    exp_q.delete();
    m_ready = 1'b0; sweep_left = DEPTH; exp_done = 1'b0; exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b1;
    i_valid = 0; i_halt = 0; i_flush = 0; i_wen = 0;
    i_tag = '0; i_addr = '0; i_data = '0; i_wmask = '0;
    #2;
    do_reset();

    // Initial sweep of 16 cycles, then every row reads as the init value.
    idle(16);
    read_all();

    // Masked write followed by a read of the same row.
    cyc(1, 1, 4'd5, 8'hFF, 4'b0101, 1'b1, 0, 0);
    rd(4'd5, 1'b0);

    // Halt held the cycle after a request: response must stay frozen.
    rd(4'd3, 1'b1);
    cyc(1, 1, 4'd3, 8'h55, 4'hF, 1'b0, 0, 1);
    cyc(1, 0, 4'd4, 8'h00, 4'h0, 1'b0, 1, 1);
    cyc(0, 0, 4'd0, 8'h00, 4'h0, 1'b0, 0, 1);
    idle(1);

    // Flush with a concurrent write, then a halt of 3 cycles at counter 7 (19 cycles total).
    cyc(1, 1, 4'd2, 8'hAA, 4'hF, 1'b0, 1, 0);
    idle(7);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, '0, '0, 0, 1);
    idle(9);
    rd(4'd2, 1'b1);

    // Requests held during a sweep are dropped and modify nothing.
    cyc(0, 0, '0, '0, '0, '0, 1, 0);
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 1, AW'($urandom), RW'($urandom), 4'hF, TW'($urandom), 0, 0);
    read_all();

    // Randomised traffic with occasional halts and flushes.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(99) < 70, $urandom_range(1), AW'($urandom), RW'($urandom),
          NB'($urandom), TW'($urandom), $urandom_range(99) < 2, $urandom_range(99) < 10);
    idle(DEPTH + 2);
    read_all();

    // Reset mid-sweep, then reset during RUN with a response pending.
    do_reset();
    idle(5);
    do_reset();
    idle(DEPTH);
    cyc(1, 1, 4'd9, 8'h00, 4'hF, 1'b1, 0, 0);
    do_reset();
    idle(DEPTH);
    read_all();

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/status_array_ctrl.md
Name: status_array_ctrl

Overview:
- Parametrised status-array controller that bundles per-row, per-block status storage with a built-in initialisation sweep.
- Adds an on-demand flush (re-sweep) mode.
- Sits between the cache lookup front end and the hit/miss logic. It supplies per-block status bits (valid/LRU/etc.) one cycle after a request and applies masked status updates.
- Generalises depth, block count, status width and initial value.

Parameters:
- TAG_WIDTH, 1, width of the sideband tag carried from request to response.
- ADDR_WIDTH, 4, row index width; DEPTH = 2^ADDR_WIDTH rows.
- NUM_BLOCKS, 4, status blocks per row; one write-mask bit each.
- STATUS_WIDTH, 2, bits per block. ROW_WIDTH = NUM_BLOCKS*STATUS_WIDTH (localparam).
- INIT_VALUE, 0, STATUS_WIDTH-bit value written to every block by a sweep.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- i_halt  in  1  global stall; freezes all state and outputs.
- i_flush  in  1  request a re-initialisation sweep.
- i_tag  in  TAG_WIDTH  request sideband.
- i_addr  in  ADDR_WIDTH  row index.
- i_data  in  ROW_WIDTH  write data; block b = bits [b*STATUS_WIDTH +: STATUS_WIDTH].
- i_wen  in  1  request is a masked write.
- i_wmask  in  NUM_BLOCKS  per-block write enable.
- i_valid  in  1  request present.
- o_tag  out  TAG_WIDTH  tag of the response.
- o_data  out  ROW_WIDTH  row contents as they were before the request's write.
- o_valid  out  1  response valid.
- o_ready  out  1  block accepts requests (state RUN).
- o_sweep_done  out  1  one-cycle pulse when a sweep finishes.

Behaviour:
- **Reset** (async, arst_n=0):
  - State = SWEEP, sweep counter = 0.
  - o_valid=0, o_tag=0, o_data=0, o_ready=0, o_sweep_done=0.
  - Array contents are undefined until the sweep completes.
- **Halt priority:** i_halt=1 freezes the FSM, counter, array and all registered outputs for that cycle. i_flush and requests are ignored while halted.
- **SWEEP** (per non-halted cycle):
  - Write INIT_VALUE to all blocks of row[counter], then counter+1.
  - At counter = DEPTH-1, write the last row and enter RUN next cycle. o_sweep_done=1 for exactly that first RUN cycle.
  - A halt-free sweep takes DEPTH cycles.
  - o_ready=0 and o_valid=0 throughout.
  - Requests with i_valid=1 are dropped: no response, no write.
  - i_flush=1 during SWEEP restarts the counter at 0 the next cycle.
- **RUN:**
  - o_ready=1.
  - **Accepted request:** i_valid & !i_halt.
    - Next cycle: o_valid=1, o_tag=i_tag, o_data=row[i_addr] before any write in this cycle (read-before-write).
    - If i_wen=1, each block b with i_wmask[b]=1 takes the i_data slice; other blocks are unchanged.
    - Writes also produce a response.
  - **No accepted request:** o_valid=0 next cycle; o_tag and o_data hold their last values.
  - **Latency and hazards:** fixed 1 cycle. Back-to-back requests to the same row: the second returns the data written by the first.
- **Flush in RUN:** i_flush & !i_halt.
  - A request accepted in the same cycle is processed (response + write) first.
  - The next cycle is SWEEP with counter=0.
  - o_ready drops in the cycle after i_flush.
- **Counter:** ADDR_WIDTH bits; terminal detection at all-ones. There is no wrap into RUN without completing the last row.
- **Mid-operation reset:** any state returns immediately to SWEEP/counter 0 with outputs as at reset. A pending response is discarded.

Test Plan:
- Reset release, no halt, defaults (DEPTH=16):
  - o_ready=0 for 16 cycles; o_sweep_done pulses once on cycle 16, with o_ready=1 the same cycle.
  - Reads of addr 0..15 return 8'h00.
- Masked write then read:
  - Write addr 5, data 8'hFF, wmask 4'b0101, tag 1 -> response o_data=8'h00, o_tag=1.
  - Next read addr 5 -> o_data=8'h33.
- Halt during sweep and during response:
  - Assert i_halt for 3 cycles at counter=7 -> sweep takes 19 cycles total.
  - Halt asserted the cycle after a request -> o_valid, o_data and o_tag hold until i_halt deasserts.
- Flush with concurrent write:
  - Write addr 2 = 8'hAA with i_flush=1 -> response o_data=8'h00 next cycle, o_ready=0.
  - After 16 cycles, read addr 2 -> 8'h00.
- Requests while not ready:
  - i_valid=1 held during sweep -> o_valid stays 0 and no row is modified.
- Reset mid-operation with INIT_VALUE=2'b11:
  - arst_n pulsed low mid-sweep and during RUN -> outputs zero immediately, sweep restarts.
  - Post-sweep reads -> 8'hFF.
